// File: rtl/shift_arb_pkg.sv
// Shared types and sizing helpers for the two-requester iterative shifter sequencer.
package shift_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Remaining-count width: the largest amount that ever enters BUSY is
  // min(WIDTH-1, 2^SHW-1), so the narrower of the two sizes is enough.
  function automatic int rem_bits(input int width, input int shw);
    int w;
    w = (width > 2) ? $clog2(width) : 1;
    return (w < shw) ? w : shw;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift stage: moves the operand by 0..STEP bits, zero-filled.
module shift_step
  import shift_arb_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int STEP  = 4,
  localparam int K_W   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [K_W-1:0]   amt_i,
  input  logic             dir_i,
  output logic [WIDTH-1:0] data_o
);

  assign data_o = (dir_i == DIR_RIGHT) ? (data_i >> amt_i) : (data_i << amt_i);

endmodule

// File: rtl/shift_arb_seq.sv
// Round-robin arbiter and sequencer sharing one small shift stage between two
// requesters; the result returns on a single valid/ready port tagged with its id.
module shift_arb_seq
  import shift_arb_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = 5,
  parameter int STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_in,
  input  logic [SHW-1:0]   req0_shift,
  input  logic             req0_dir,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_in,
  input  logic [SHW-1:0]   req1_shift,
  input  logic             req1_dir,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_id
);

  localparam int REM_W = rem_bits(WIDTH, SHW);
  localparam int K_W   = $clog2(STEP + 1);

  state_e             state_q, state_d;
  logic               rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic               dir_q, dir_d;
  logic               id_q, id_d;

  logic               gnt_id;
  logic               accept;
  logic [WIDTH-1:0]   sel_in;
  logic [SHW-1:0]     sel_shift;
  logic               sel_dir;
  logic [K_W-1:0]     k;
  logic [WIDTH-1:0]   step_out;

  // Grant follows the only valid requester; rr_ptr breaks ties.
  always_comb begin
    gnt_id     = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
    req0_ready = !rst && (state_q == IDLE) && req0_valid && (gnt_id == 1'b0);
    req1_ready = !rst && (state_q == IDLE) && req1_valid && (gnt_id == 1'b1);
    accept     = req0_ready || req1_ready;
    sel_in     = gnt_id ? req1_in    : req0_in;
    sel_shift  = gnt_id ? req1_shift : req0_shift;
    sel_dir    = gnt_id ? req1_dir   : req0_dir;
    k          = (int'(rem_q) > STEP) ? K_W'(STEP) : K_W'(rem_q);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data_i (data_q),
    .amt_i  (k),
    .dir_i  (dir_q),
    .data_o (step_out)
  );

  // NOTE: every variable gets its hold value first, so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    data_d   = data_q;
    rem_d    = rem_q;
    dir_d    = dir_q;
    id_d     = id_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          id_d     = gnt_id;
          dir_d    = sel_dir;
          rr_ptr_d = ~gnt_id;
          if (int'(sel_shift) >= WIDTH) begin
            data_d  = '0;
            state_d = DONE;
          end else if (sel_shift == '0) begin
            data_d  = sel_in;
            state_d = DONE;
          end else begin
            data_d  = sel_in;
            rem_d   = sel_shift[REM_W-1:0];
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        data_d = step_out;
        rem_d  = rem_q - REM_W'(k);
        if (rem_d == '0) state_d = DONE;
      end
      DONE: begin
        // The handshake cycle returns to IDLE only; the bubble is intentional.
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      data_q   <= '0;
      rem_q    <= '0;
      dir_q    <= DIR_LEFT;
      id_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      rem_q    <= rem_d;
      dir_q    <= dir_d;
      id_q     <= id_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;
  assign out_id    = id_q;

endmodule

// File: tb/tb_shift_arb_seq.sv
// Directed, table-driven bench for shift_arb_seq (WIDTH=16, SHW=5, STEP=4).
module tb_shift_arb_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_dir;
  logic [15:0] req0_in;
  logic [4:0]  req0_shift;
  logic        req1_valid, req1_ready, req1_dir;
  logic [15:0] req1_in;
  logic [4:0]  req1_shift;
  logic        out_valid, out_ready, out_id;
  logic [15:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  shift_arb_seq #(.WIDTH(16), .SHW(5), .STEP(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_in    (req0_in),
    .req0_shift (req0_shift),
    .req0_dir   (req0_dir),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_in    (req1_in),
    .req1_shift (req1_shift),
    .req1_dir   (req1_dir),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] din;
    logic [4:0]  sh;
    logic        dir;
    logic        id;
    logic [15:0] exp_data;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req0_valid = 1'b0; req0_in = '0; req0_shift = '0; req0_dir = 1'b0;
    req1_valid = 1'b0; req1_in = '0; req1_shift = '0; req1_dir = 1'b0;
  endtask

  task automatic drive_req(input logic id, input logic [15:0] din, input logic [4:0] sh,
                           input logic dir);
    if (id) begin
      req1_valid = 1'b1; req1_in = din; req1_shift = sh; req1_dir = dir;
    end else begin
      req0_valid = 1'b1; req0_in = din; req0_shift = sh; req0_dir = dir;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    clear_reqs();
    out_ready = 1'b1;
    drive_req(v.id, v.din, v.sh, v.dir);
    #1;
    check("vec_ready_granted", v.id ? req1_ready : req0_ready, 1);
    check("vec_ready_other",   v.id ? req0_ready : req1_ready, 0);
    tick();
    clear_reqs();
    cyc = 1;
    while (!out_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    check("vec_latency", cyc, v.exp_lat);
    check("vec_data", out_data, v.exp_data);
    check("vec_id", out_id, v.id);
    tick();
    check("vec_valid_drop", out_valid, 0);
  endtask

  vec_t vecs[9];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   ng;
    logic last_gnt;
    bit   prev_acc;
    int   cyc;

    vecs[0] = '{16'h0001,  5, 1'b0, 1'b0, 16'h0020, 3};
    vecs[1] = '{16'h8000, 15, 1'b1, 1'b1, 16'h0001, 5};
    vecs[2] = '{16'hFFFF, 16, 1'b0, 1'b0, 16'h0000, 1};
    vecs[3] = '{16'hA5A5,  0, 1'b0, 1'b1, 16'hA5A5, 1};
    vecs[4] = '{16'hFFFF, 31, 1'b1, 1'b0, 16'h0000, 1};
    vecs[5] = '{16'h1234,  4, 1'b0, 1'b1, 16'h2340, 2};
    vecs[6] = '{16'hF00F,  7, 1'b1, 1'b0, 16'h01E0, 3};
    vecs[7] = '{16'h8001, 15, 1'b0, 1'b1, 16'h8000, 5};
    vecs[8] = '{16'hABCD,  8, 1'b1, 1'b0, 16'h00AB, 3};

    // Reset state, with both requesters pushing.
    clear_reqs();
    out_ready = 1'b1;
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    tick();
    tick();
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_id", out_id, 0);
    rst = 1'b0;
    clear_reqs();
    tick();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Fairness: both valid every cycle from rr_ptr=0.
    do_reset();
    clear_reqs();
    out_ready = 1'b1;
    drive_req(1'b0, 16'h1111, 5'd0, 1'b0);
    drive_req(1'b1, 16'h2222, 5'd0, 1'b0);
    #1;
    ng = 0;
    prev_acc = 1'b0;
    last_gnt = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (prev_acc) begin
        check("fair_bubble", int'(req0_ready) + int'(req1_ready), 0);
        check("fair_out_valid", out_valid, 1);
        check("fair_out_id", out_id, last_gnt);
        check("fair_out_data", out_data, last_gnt ? 16'h2222 : 16'h1111);
        prev_acc = 1'b0;
      end else begin
        check("fair_one_ready", int'(req0_ready) + int'(req1_ready), 1);
        if (req0_ready || req1_ready) begin
          last_gnt = req1_ready;
          check("fair_grant_order", last_gnt, 32'(ng % 2));
          ng++;
          prev_acc = 1'b1;
        end
      end
      tick();
    end
    check("fair_grant_count", ng, 4);

    // Backpressure: hold a result in DONE for 10 cycles.
    clear_reqs();
    out_ready = 1'b0;
    drive_req(1'b0, 16'h5A5A, 5'd0, 1'b0);
    #1;
    tick();
    drive_req(1'b1, 16'h0F0F, 5'd3, 1'b1);
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("bp_latency", cyc, 1);
    for (int c = 0; c < 10; c++) begin
      check("bp_out_valid", out_valid, 1);
      check("bp_out_data", out_data, 16'h5A5A);
      check("bp_out_id", out_id, 0);
      check("bp_readies", {req0_ready, req1_ready}, 0);
      tick();
    end
    out_ready = 1'b1;
    clear_reqs();
    tick();
    check("bp_release_valid", out_valid, 0);
    drive_req(1'b1, 16'h0F0F, 5'd3, 1'b1);
    #1;
    check("bp_idle_ready", req1_ready, 1);
    clear_reqs();
    #1;

    // Reset during BUSY of a shift=15 request.
    tick();
    drive_req(1'b1, 16'h8000, 5'd15, 1'b1);
    #1;
    check("mid_accept_ready", req1_ready, 1);
    tick();
    clear_reqs();
    tick();
    check("mid_busy_no_valid", out_valid, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_post_rst_valid", out_valid, 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      check("mid_no_stale_result", out_valid, 0);
    end
    drive_req(1'b0, 16'h0003, 5'd1, 1'b0);
    drive_req(1'b1, 16'h0007, 5'd1, 1'b0);
    #1;
    check("mid_rr_ready0", req0_ready, 1);
    check("mid_rr_ready1", req1_ready, 0);
    tick();
    clear_reqs();
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("mid_result_latency", cyc, 2);
    check("mid_result_id", out_id, 0);
    check("mid_result_data", out_data, 16'h0006);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
